multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Main control unit for the multi-cycle MIPS datapath; successor to the single-cycle combinational decoder.
- A Moore FSM sequences each instruction through fetch, decode, execute, memory and writeback. Every step is one or more clock cycles.
- Adds a memory-ready handshake, an illegal-opcode trap mode and a retired-instruction counter.
- Drives the shared PC, IR, register file, ALU and unified-memory muxes.

Parameters:
- OP_W, 6, opcode and funct field width.
- ALUOP_W, 3, ALU_op_o width. Encoding: ADD=000, SUB=001, RTYPE=010, SLT=100.
- CNT_W, 32, width of the retired-instruction counter.
- TRAP_EN, 1, illegal-opcode handling. 1 = park in TRAP until reset. 0 = set illegal_o and return to FETCH.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- instr_op_i  in  OP_W  IR[31:26]. Valid from DECODE onward.
- instr_funct_i  in  OP_W  IR[5:0].
- mem_ready_i  in  1  memory completes the current access this cycle.
- zero_i  in  1  ALU zero flag.
- PCWrite_o  out  1  unconditional PC load.
- PCWriteCond_o  out  1  PC load if zero_i.
- IorD_o  out  1  memory address: 0 = PC, 1 = ALUOut.
- MemRead_o  out  1  memory read request.
- MemWrite_o  out  1  memory write request.
- IRWrite_o  out  1  IR load.
- MemtoReg_o  out  2  write-data select: 0 = ALUOut, 1 = MDR, 2 = PC.
- RegDst_o  out  2  destination select: 0 = rt, 1 = rd, 2 = $31.
- RegWrite_o  out  1  register file write.
- ALUSrcA_o  out  1  ALU A select: 0 = PC, 1 = A.
- ALUSrcB_o  out  2  ALU B select: 0 = B, 1 = 4, 2 = sign-extended imm, 3 = sign-extended imm<<2.
- ALU_op_o  out  ALUOP_W  ALU operation.
- PCSource_o  out  2  PC source: 0 = ALU, 1 = ALUOut, 2 = jump target, 3 = register A.
- state_o  out  4  current state, for debug.
- illegal_o  out  1  sticky illegal-opcode flag.
- retired_o  out  CNT_W  count of completed instructions.

Behaviour:
- Opcodes decoded in DECODE:
  - R-type 0x00; jr is R-type with funct 0x08.
  - beq 0x04, addi 0x08, slti 0x0A, lw 0x23, sw 0x2B, j 0x02, jal 0x03.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEXEC=6, RTWB=7, BRANCH=8, IEXEC=9, IWB=10, JUMP=11, JAL=12, JR=13, TRAP=14.
- Reset (rst_i low, asynchronous):
  - state=FETCH, illegal_o=0, retired_o=0.
  - All strobes forced 0 while rst_i is low: PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite.
  - Reset mid-instruction aborts it; no partial writeback.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALU_op=ADD, PCSource=0.
  - IRWrite and PCWrite assert only in the cycle mem_ready_i=1; that cycle the FSM goes to DECODE. Otherwise it stays in FETCH with MemRead held high.
- DECODE:
  - ALUSrcA=0, ALUSrcB=3, ALU_op=ADD (branch target precompute).
  - Next state by opcode:
    - lw/sw -> MEMADR
    - R-type with funct 0x08 -> JR; other R-type -> RTEXEC
    - beq -> BRANCH
    - addi/slti -> IEXEC
    - j -> JUMP
    - jal -> JAL
    - any other opcode -> illegal
  - Illegal: illegal_o<=1; next state TRAP if TRAP_EN=1, else FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=2, ADD. Next MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. Wait for mem_ready_i, then MEMWB.
- MEMWB: RegWrite=1, RegDst=0, MemtoReg=1. Then FETCH.
- MEMWR: MemWrite=1, IorD=1, held until mem_ready_i=1. Then FETCH.
- RTEXEC: ALUSrcA=1, ALUSrcB=0, ALU_op=RTYPE. Then RTWB.
- RTWB: RegWrite=1, RegDst=1, MemtoReg=0. Then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=0, ALU_op=SUB, PCWriteCond=1, PCSource=1. Then FETCH.
- IEXEC: ALUSrcA=1, ALUSrcB=2, ALU_op=ADD for addi, SLT for slti. Then IWB.
  - The opcode is captured into an internal register at DECODE. IWB does not re-sample instr_op_i.
- IWB: RegWrite=1, RegDst=0, MemtoReg=0. Then FETCH.
- JUMP: PCWrite=1, PCSource=2. Then FETCH.
- JAL: RegWrite=1, RegDst=2, MemtoReg=2, PCWrite=1, PCSource=2. Then FETCH.
  - PC here already holds PC+4, so the link value is correct.
- JR: PCWrite=1, PCSource=3. Then FETCH.
- TRAP: all strobes 0, state held; only reset exits.
- Defaults: outputs not listed for a state are 0.
- Cycle counts with mem_ready_i tied to 1:
  - lw 5, sw 4, R-type 4, addi/slti 4.
  - beq 3, j 3, jal 3, jr 3.
- retired_o:
  - Increments by 1 on each transition into FETCH from MEMWB, MEMWR, RTWB, BRANCH, IWB, JUMP, JAL or JR.
  - Does not increment on the illegal path.
  - Wraps modulo 2^CNT_W.
- illegal_o is sticky until reset.

Decomposition:
- Shared package mc_pkg holds:
  - opcode and funct constants;
  - state localparams;
  - ALU_op encodings;
  - mux-select codes.
- Optional sub-module mc_opdecode: combinational opcode/funct to instruction-class one-hot. Used in DECODE and for the captured opcode.

Test Plan:
- Reset, then lw (0x23) with mem_ready_i delayed 2 cycles in both FETCH and MEMRD:
  - state sequence 0,0,0,1,2,3,3,3,4,0;
  - one RegWrite pulse with MemtoReg=1;
  - retired_o=1.
- R-type add (funct 0x20), then jr (funct 0x08), ready=1:
  - 4 cycles with RegDst=1, ALU_op=010;
  - then 3 cycles, PCSource=3 with PCWrite=1 in state 13;
  - retired_o=2.
- beq with zero_i=1, then zero_i=0: PCWriteCond=1, PCSource=1, ALU_op=001 in state 8 both times; exactly 3 cycles each.
- jal (0x03): in state 12, RegDst=2, MemtoReg=2, RegWrite=1, PCWrite=1, PCSource=2.
- Opcode 0x3F:
  - TRAP_EN=1: illegal_o=1, state stays 14 for 20 cycles with no strobes, retired_o unchanged.
  - TRAP_EN=0: state returns to 0 next cycle.
- Assert rst_i low during MEMWR while waiting on ready:
  - MemWrite drops immediately (asynchronous);
  - after release, state=0 and retired_o=0.
- CNT_W=4 build, 17 j instructions: retired_o wraps to 1.

Source files
------------

// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared constants, state encoding and helpers for the multi-cycle control unit
package mc_pkg;

    // Primary opcodes (IR[31:26]) and the one funct value the controller cares about
    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_JAL   = 6'h03;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_SLTI  = 6'h0A;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;
    localparam logic [5:0] FUNCT_JR  = 6'h08;

    // Controller states; the numeric values are visible on state_o
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEXEC = 4'd6,
        S_RTWB   = 4'd7,
        S_BRANCH = 4'd8,
        S_IEXEC  = 4'd9,
        S_IWB    = 4'd10,
        S_JUMP   = 4'd11,
        S_JAL    = 4'd12,
        S_JR     = 4'd13,
        S_TRAP   = 4'd14
    } state_e;

    // ALU operation encodings
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_RTYPE = 3'b010;
    localparam logic [2:0] ALU_SLT   = 3'b100;

    // Datapath mux select codes
    localparam logic       IORD_PC      = 1'b0;
    localparam logic       IORD_ALUOUT  = 1'b1;
    localparam logic [1:0] WD_ALUOUT    = 2'd0;
    localparam logic [1:0] WD_MDR       = 2'd1;
    localparam logic [1:0] WD_PC        = 2'd2;
    localparam logic [1:0] DST_RT       = 2'd0;
    localparam logic [1:0] DST_RD       = 2'd1;
    localparam logic [1:0] DST_RA       = 2'd2;
    localparam logic       SRCA_PC      = 1'b0;
    localparam logic       SRCA_REG     = 1'b1;
    localparam logic [1:0] SRCB_REG     = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] PCSRC_REGA   = 2'd3;

    // Instruction-class one-hot bit positions
    localparam int CLS_RTYPE = 0;
    localparam int CLS_JR    = 1;
    localparam int CLS_LW    = 2;
    localparam int CLS_SW    = 3;
    localparam int CLS_BEQ   = 4;
    localparam int CLS_ADDI  = 5;
    localparam int CLS_SLTI  = 6;
    localparam int CLS_J     = 7;
    localparam int CLS_JAL   = 8;
    localparam int CLS_ILL   = 9;
    localparam int CLS_W     = 10;

    typedef logic [CLS_W-1:0] cls_t;

    // State that follows DECODE for a given instruction class
    function automatic state_e class_next_state(input cls_t cls, input logic trap_en);
        state_e nxt;
        nxt = S_FETCH;
        if (cls[CLS_LW] || cls[CLS_SW]) nxt = S_MEMADR;
        if (cls[CLS_RTYPE])             nxt = S_RTEXEC;
        if (cls[CLS_JR])                nxt = S_JR;
        if (cls[CLS_BEQ])               nxt = S_BRANCH;
        if (cls[CLS_ADDI] || cls[CLS_SLTI]) nxt = S_IEXEC;
        if (cls[CLS_J])                 nxt = S_JUMP;
        if (cls[CLS_JAL])               nxt = S_JAL;
        if (cls[CLS_ILL])               nxt = trap_en ? S_TRAP : S_FETCH;
        return nxt;
    endfunction

endpackage

// File: rtl/mc_opdecode.sv
// rtl/mc_opdecode.sv - opcode/funct to instruction-class one-hot decoder
module mc_opdecode
    import mc_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic [OP_W-1:0] op_i,
    input  logic [OP_W-1:0] funct_i,
    output cls_t            cls_o
);

    // Exactly one class bit is set for every opcode; unknown opcodes land in CLS_ILL
    always_comb begin
        cls_o = '0;
        case (op_i)
            OP_W'(OPC_RTYPE): begin
                if (funct_i == OP_W'(FUNCT_JR)) cls_o[CLS_JR]    = 1'b1;
                else                            cls_o[CLS_RTYPE] = 1'b1;
            end
            OP_W'(OPC_LW):   cls_o[CLS_LW]   = 1'b1;
            OP_W'(OPC_SW):   cls_o[CLS_SW]   = 1'b1;
            OP_W'(OPC_BEQ):  cls_o[CLS_BEQ]  = 1'b1;
            OP_W'(OPC_ADDI): cls_o[CLS_ADDI] = 1'b1;
            OP_W'(OPC_SLTI): cls_o[CLS_SLTI] = 1'b1;
            OP_W'(OPC_J):    cls_o[CLS_J]    = 1'b1;
            OP_W'(OPC_JAL):  cls_o[CLS_JAL]  = 1'b1;
            default:         cls_o[CLS_ILL]  = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - Moore control FSM for the multi-cycle MIPS datapath
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 32,
    parameter bit TRAP_EN = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [OP_W-1:0]    instr_op_i,
    input  logic [OP_W-1:0]    instr_funct_i,
    input  logic               mem_ready_i,
    input  logic               zero_i,
    output logic               PCWrite_o,
    output logic               PCWriteCond_o,
    output logic               IorD_o,
    output logic               MemRead_o,
    output logic               MemWrite_o,
    output logic               IRWrite_o,
    output logic [1:0]         MemtoReg_o,
    output logic [1:0]         RegDst_o,
    output logic               RegWrite_o,
    output logic               ALUSrcA_o,
    output logic [1:0]         ALUSrcB_o,
    output logic [ALUOP_W-1:0] ALU_op_o,
    output logic [1:0]         PCSource_o,
    output logic [3:0]         state_o,
    output logic               illegal_o,
    output logic [CNT_W-1:0]   retired_o
);

    state_e           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic             retire;
    cls_t             cls_dec;

    logic       pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write;
    logic       iord, alu_src_a;
    logic [1:0] mem_to_reg, reg_dst, alu_src_b, pc_source;
    logic [2:0] alu_op;

    // The branch decision itself is made in the datapath by gating PCWriteCond with zero_i
    logic unused_zero;
    assign unused_zero = zero_i;

    mc_opdecode #(.OP_W(OP_W)) u_opdecode (
        .op_i    (instr_op_i),
        .funct_i (instr_funct_i),
        .cls_o   (cls_dec)
    );

    // State, sticky illegal flag, retired counter and the opcode captured at DECODE
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            retired_q <= '0;
            op_q      <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
            op_q      <= op_d;
        end
    end

    // Next-state logic; retire marks every completing transition back into FETCH
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        op_d      = op_q;
        retire    = 1'b0;
        case (state_q)
            S_FETCH:  if (mem_ready_i) state_d = S_DECODE;
            S_DECODE: begin
                op_d      = instr_op_i;
                illegal_d = illegal_q | cls_dec[CLS_ILL];
                state_d   = class_next_state(cls_dec, TRAP_EN);
            end
            S_MEMADR: state_d = (op_q == OP_W'(OPC_LW)) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready_i) state_d = S_MEMWB;
            S_MEMWB:  begin state_d = S_FETCH; retire = 1'b1; end
            S_MEMWR:  if (mem_ready_i) begin state_d = S_FETCH; retire = 1'b1; end
            S_RTEXEC: state_d = S_RTWB;
            S_RTWB:   begin state_d = S_FETCH; retire = 1'b1; end
            S_BRANCH: begin state_d = S_FETCH; retire = 1'b1; end
            S_IEXEC:  state_d = S_IWB;
            S_IWB:    begin state_d = S_FETCH; retire = 1'b1; end
            S_JUMP:   begin state_d = S_FETCH; retire = 1'b1; end
            S_JAL:    begin state_d = S_FETCH; retire = 1'b1; end
            S_JR:     begin state_d = S_FETCH; retire = 1'b1; end
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_FETCH;
        endcase
        retired_d = retired_q + (retire ? CNT_W'(1) : CNT_W'(0));
    end

    // Per-state datapath controls; anything not set by a state stays at zero
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        iord          = IORD_PC;
        mem_to_reg    = WD_ALUOUT;
        reg_dst       = DST_RT;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_REG;
        alu_op        = ALU_ADD;
        pc_source     = PCSRC_ALU;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready_i;
                pc_write  = mem_ready_i;
            end
            S_DECODE: alu_src_b = SRCB_IMM_SH2;
            S_MEMADR: begin
                alu_src_a = SRCA_REG;
                alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = IORD_ALUOUT;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                reg_dst    = DST_RT;
                mem_to_reg = WD_MDR;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = IORD_ALUOUT;
            end
            S_RTEXEC: begin
                alu_src_a = SRCA_REG;
                alu_src_b = SRCB_REG;
                alu_op    = ALU_RTYPE;
            end
            S_RTWB: begin
                reg_write  = 1'b1;
                reg_dst    = DST_RD;
                mem_to_reg = WD_ALUOUT;
            end
            S_BRANCH: begin
                alu_src_a     = SRCA_REG;
                alu_src_b     = SRCB_REG;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
            end
            S_IEXEC: begin
                alu_src_a = SRCA_REG;
                alu_src_b = SRCB_IMM;
                alu_op    = (op_q == OP_W'(OPC_SLTI)) ? ALU_SLT : ALU_ADD;
            end
            S_IWB: begin
                reg_write  = 1'b1;
                reg_dst    = DST_RT;
                mem_to_reg = WD_ALUOUT;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
            end
            S_JAL: begin
                reg_write  = 1'b1;
                reg_dst    = DST_RA;
                mem_to_reg = WD_PC;
                pc_write   = 1'b1;
                pc_source  = PCSRC_JUMP;
            end
            S_JR: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_REGA;
            end
            default: ;
        endcase
    end

    // Strobes are gated by reset directly so they drop the moment rst_i falls
    assign PCWrite_o     = pc_write      & rst_i;
    assign PCWriteCond_o = pc_write_cond & rst_i;
    assign MemRead_o     = mem_read      & rst_i;
    assign MemWrite_o    = mem_write     & rst_i;
    assign IRWrite_o     = ir_write      & rst_i;
    assign RegWrite_o    = reg_write     & rst_i;

    assign IorD_o     = iord;
    assign MemtoReg_o = mem_to_reg;
    assign RegDst_o   = reg_dst;
    assign ALUSrcA_o  = alu_src_a;
    assign ALUSrcB_o  = alu_src_b;
    assign ALU_op_o   = ALUOP_W'(alu_op);
    assign PCSource_o = pc_source;
    assign state_o    = state_q;
    assign illegal_o  = illegal_q;
    assign retired_o  = retired_q;

endmodule
